// File: rtl/peripheral_axi4_slave_write.sv
// AXI4 write-channel responder: one AW burst at a time, per-beat byte writes
// on a simple memory port, single B response per burst.
// Optional feature macro: AXI4_SLAVE_WRAP_BURST_EN (WRAP burst address support).
module peripheral_axi4_slave_write #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ID_WIDTH-1:0]     awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [AXI_ID_WIDTH-1:0]     bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  output logic                        mem_we,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_strb
);

  localparam int unsigned AW       = AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE_MAX = $clog2(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  // Context of the burst currently being served, captured at AW time.
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [AW-1:0]           addr;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    err;
  } ctx_t;

  state_t                  state_q, state_d;
  ctx_t                    ctx_q, ctx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    proto_q, proto_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;

  logic          aw_hs, w_hs, b_hs;
  logic          aw_err, size_err, wrap_err;
  logic          last_beat, wlast_bad;
  logic [AW-1:0] beat_bytes, addr_next;

  assign aw_hs     = awvalid & awready_q;
  assign w_hs      = wvalid & wready_q;
  assign b_hs      = bvalid_q & bready;
  assign last_beat = (cnt_q == 8'd0);
  assign wlast_bad = (last_beat != wlast);

  // AW-time burst legality check.
  always_comb begin
    size_err = (awsize > 3'(SIZE_MAX));
`ifdef AXI4_SLAVE_WRAP_BURST_EN
    wrap_err = (awburst == BURST_WRAP) &&
               !((awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15));
`else
    wrap_err = (awburst == BURST_WRAP);
`endif
    aw_err = size_err | wrap_err | (awburst == BURST_RSVD);
  end

`ifdef AXI4_SLAVE_WRAP_BURST_EN
  logic [AW-1:0] wrap_len_q;
  logic [AW-1:0] wrap_base;

  // Wrap window length (len+1)*B, captured with the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_len_q <= '0;
    end else if (aw_hs) begin
      wrap_len_q <= AW'({1'b0, awlen} + 9'd1) << awsize;
    end
  end
`endif

  // Address of the following beat for the latched burst type.
  always_comb begin
    beat_bytes = AW'(1) << ctx_q.size;
    addr_next  = ctx_q.addr;
`ifdef AXI4_SLAVE_WRAP_BURST_EN
    wrap_base  = ctx_q.addr & ~(wrap_len_q - AW'(1));
`endif
    case (ctx_q.burst)
      BURST_FIXED: addr_next = ctx_q.addr;
      BURST_INCR:  addr_next = (ctx_q.addr & ~(beat_bytes - AW'(1))) + beat_bytes;
`ifdef AXI4_SLAVE_WRAP_BURST_EN
      BURST_WRAP:  addr_next = wrap_base +
                               ((ctx_q.addr + beat_bytes - wrap_base) & (wrap_len_q - AW'(1)));
`endif
      default:     addr_next = ctx_q.addr;
    endcase
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    cnt_d   = cnt_q;
    proto_d = proto_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          ctx_d.id    = awid;
          ctx_d.addr  = awaddr;
          ctx_d.size  = awsize;
          ctx_d.burst = awburst;
          ctx_d.err   = aw_err;
          cnt_d       = awlen;
          proto_d     = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          ctx_d.addr = addr_next;
          cnt_d      = cnt_q - 8'd1;
          if (wlast_bad) begin
            proto_d = 1'b1;
          end
          if (last_beat) begin
            state_d = RESP;
            bid_d   = ctx_q.id;
            bresp_d = (ctx_q.err | proto_q | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          bid_d   = '0;
          bresp_d = RESP_OKAY;
        end
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  // State and registered outputs; all cleared while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctx_q     <= '0;
      cnt_q     <= '0;
      proto_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      cnt_q     <= cnt_d;
      proto_q   <= proto_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  // Memory-side port follows the W handshake in the same cycle.
  assign mem_we    = w_hs & ~ctx_q.err;
  assign mem_addr  = w_hs ? ctx_q.addr : '0;
  assign mem_wdata = w_hs ? wdata : '0;
  assign mem_strb  = w_hs ? wstrb : '0;

endmodule

// File: tb/tb_peripheral_axi4_slave_write.sv
// Directed bench for peripheral_axi4_slave_write (64-bit bus, 64-bit address).
module tb_peripheral_axi4_slave_write;

  logic        clk, rst;
  logic [3:0]  awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_strb;

  int errors = 0;
  int checks = 0;

  peripheral_axi4_slave_write #(
    .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 64'(awready), 64'd0);
    check({tag, "_wready"},  64'(wready),  64'd0);
    check({tag, "_bvalid"},  64'(bvalid),  64'd0);
    check({tag, "_bid"},     64'(bid),     64'd0);
    check({tag, "_bresp"},   64'(bresp),   64'd0);
    check({tag, "_mem_we"},  64'(mem_we),  64'd0);
    check({tag, "_mem_addr"},  mem_addr,  64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_strb"},  64'(mem_strb), 64'd0);
  endtask

  task automatic aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 20) begin
      tick();
      n++;
    end
    check("aw_ready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    check("wready_after_aw", 64'(wready), 64'd1);
  endtask

  task automatic wb(input string tag, input logic [63:0] data, input logic [7:0] strb,
                    input logic last, input logic exp_we, input logic [63:0] exp_addr);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 20) begin
      tick();
      n++;
    end
    #1;
    check({tag, "_wready"}, 64'(wready), 64'd1);
    check({tag, "_we"}, 64'(mem_we), 64'(exp_we));
    if (exp_we) begin
      check({tag, "_addr"},  mem_addr,  exp_addr);
      check({tag, "_wdata"}, mem_wdata, data);
      check({tag, "_strb"},  64'(mem_strb), 64'(strb));
    end
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic br(input string tag, input logic [3:0] id, input logic [1:0] resp, input int hold);
    check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    check({tag, "_wready_off"}, 64'(wready), 64'd0);
    check({tag, "_bid"}, 64'(bid), 64'(id));
    check({tag, "_bresp"}, 64'(bresp), 64'(resp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_bvalid"}, 64'(bvalid), 64'd1);
      check({tag, "_hold_bid"}, 64'(bid), 64'(id));
      check({tag, "_hold_bresp"}, 64'(bresp), 64'(resp));
      check({tag, "_hold_awready"}, 64'(awready), 64'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_clr"}, 64'(bvalid), 64'd0);
    check({tag, "_awready_back"}, 64'(awready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    bready = 1'b0;

    // Reset: outputs zero even with W traffic presented.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("post_reset_awready", 64'(awready), 64'd1);
    // W beat in IDLE is not accepted.
    tick();
    check("idle_w_wready", 64'(wready), 64'd0);
    check("idle_w_mem_we", 64'(mem_we), 64'd0);
    wvalid = 1'b0; wlast = 1'b0;

    // Single beat INCR.
    aw(4'd5, 64'h100, 8'd0, 3'd3, 2'b01);
    wb("single", 64'hDEADBEEF, 8'hFF, 1'b1, 1'b1, 64'h100);
    br("single", 4'd5, 2'b00, 0);

    // Unaligned INCR with B backpressure.
    aw(4'd9, 64'h1006, 8'd3, 3'd3, 2'b01);
    wb("incr0", 64'hA0, 8'hC0, 1'b0, 1'b1, 64'h1006);
    wb("incr1", 64'hA1, 8'hFF, 1'b0, 1'b1, 64'h1008);
    wb("incr2", 64'hA2, 8'h0F, 1'b0, 1'b1, 64'h1010);
    wb("incr3", 64'hA3, 8'hFF, 1'b1, 1'b1, 64'h1018);
    br("incr", 4'd9, 2'b00, 5);

    // WRAP burst.
    aw(4'd2, 64'h38, 8'd3, 3'd3, 2'b10);
`ifdef AXI4_SLAVE_WRAP_BURST_EN
    wb("wrap0", 64'hB0, 8'hFF, 1'b0, 1'b1, 64'h38);
    wb("wrap1", 64'hB1, 8'hFF, 1'b0, 1'b1, 64'h20);
    wb("wrap2", 64'hB2, 8'hFF, 1'b0, 1'b1, 64'h28);
    wb("wrap3", 64'hB3, 8'hFF, 1'b1, 1'b1, 64'h30);
    br("wrap", 4'd2, 2'b00, 0);
`else
    wb("wrap0", 64'hB0, 8'hFF, 1'b0, 1'b0, 64'h0);
    wb("wrap1", 64'hB1, 8'hFF, 1'b0, 1'b0, 64'h0);
    wb("wrap2", 64'hB2, 8'hFF, 1'b0, 1'b0, 64'h0);
    wb("wrap3", 64'hB3, 8'hFF, 1'b1, 1'b0, 64'h0);
    br("wrap", 4'd2, 2'b10, 0);
`endif

    // FIXED burst.
    aw(4'd7, 64'h40, 8'd2, 3'd3, 2'b00);
    wb("fixed0", 64'hC0, 8'hFF, 1'b0, 1'b1, 64'h40);
    wb("fixed1", 64'hC1, 8'hFF, 1'b0, 1'b1, 64'h40);
    wb("fixed2", 64'hC2, 8'hFF, 1'b1, 1'b1, 64'h40);
    br("fixed", 4'd7, 2'b00, 0);

    // Reserved burst type.
    aw(4'd1, 64'h80, 8'd1, 3'd3, 2'b11);
    wb("rsvd0", 64'hD0, 8'hFF, 1'b0, 1'b0, 64'h0);
    wb("rsvd1", 64'hD1, 8'hFF, 1'b1, 1'b0, 64'h0);
    br("rsvd", 4'd1, 2'b10, 0);

    // Oversized beat on a 64-bit bus.
    aw(4'd4, 64'h90, 8'd0, 3'd4, 2'b01);
    wb("size", 64'hE0, 8'hFF, 1'b1, 1'b0, 64'h0);
    br("size", 4'd4, 2'b10, 0);

    // Early wlast: writes continue, response SLVERR.
    aw(4'd6, 64'h200, 8'd3, 3'd3, 2'b01);
    wb("early0", 64'hF0, 8'hFF, 1'b0, 1'b1, 64'h200);
    wb("early1", 64'hF1, 8'hFF, 1'b1, 1'b1, 64'h208);
    wb("early2", 64'hF2, 8'hFF, 1'b0, 1'b1, 64'h210);
    wb("early3", 64'hF3, 8'hFF, 1'b1, 1'b1, 64'h218);
    br("early", 4'd6, 2'b10, 0);
    aw(4'd6, 64'h300, 8'd0, 3'd2, 2'b01);
    wb("clean", 64'h55, 8'h0F, 1'b1, 1'b1, 64'h300);
    br("clean", 4'd6, 2'b00, 0);

    // Reset mid-burst after two beats.
    aw(4'd3, 64'h400, 8'd3, 3'd3, 2'b01);
    wb("rst0", 64'h10, 8'hFF, 1'b0, 1'b1, 64'h400);
    wb("rst1", 64'h11, 8'hFF, 1'b0, 1'b1, 64'h408);
    rst = 1'b1;
    wdata = 64'h12; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    wvalid = 1'b0;
    tick();
    check("midrst_awready", 64'(awready), 64'd1);
    check("midrst_no_b", 64'(bvalid), 64'd0);
    aw(4'd8, 64'h500, 8'd0, 3'd3, 2'b01);
    wb("after_rst", 64'h77, 8'hFF, 1'b1, 1'b1, 64'h500);
    br("after_rst", 4'd8, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
